// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer.
//   - icode constants (IHALT .. IPOPQ)
//   - processor status codes (SAOK, SHLT, SADR, SINS)
//   - controller state enum
//   - needs_mem()/writes_reg(): which optional stages an icode visits
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'd0;
   localparam logic [3:0] INOP    = 4'd1;
   localparam logic [3:0] IRRMOVQ = 4'd2;
   localparam logic [3:0] IIRMOVQ = 4'd3;
   localparam logic [3:0] IRMMOVQ = 4'd4;
   localparam logic [3:0] IMRMOVQ = 4'd5;
   localparam logic [3:0] IOPQ    = 4'd6;
   localparam logic [3:0] IJXX    = 4'd7;
   localparam logic [3:0] ICALL   = 4'd8;
   localparam logic [3:0] IRET    = 4'd9;
   localparam logic [3:0] IPUSHQ  = 4'd10;
   localparam logic [3:0] IPOPQ   = 4'd11;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
      S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
   } ctrl_state_t;

   // Instructions that touch data memory
   function automatic logic needs_mem(input logic [3:0] ic);
      return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
             (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
   endfunction

   // Instructions that write the register file
   function automatic logic writes_reg(input logic [3:0] ic);
      return (ic == IRRMOVQ) || (ic == IIRMOVQ) || (ic == IOPQ)  ||
             (ic == IMRMOVQ) || (ic == ICALL)   || (ic == IRET)  ||
             (ic == IPUSHQ)  || (ic == IPOPQ);
   endfunction

endpackage

// File: rtl/seq_stage_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts consecutive cycles a memory request has waited.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (no request outstanding, or ack seen)
//   count      : request waiting this cycle without ack
//   timeout    : this is the MEM_TIMEOUT-th waiting cycle
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic timeout
);

   localparam int W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (count && cnt != LAST)
         cnt <= cnt + W'(1);
   end

   // The controller checks ack first, so an ack on this cycle still wins
   assign timeout = (cnt == LAST);

endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle sequencer for the Y86-64 SEQ datapath.
// Steps FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> PCUPD,
// runs the memory req/ack handshake and owns the status register.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                leave IDLE
//   icode, instr_valid,  fetch results, sampled with mem_ack in FETCH
//   imem_error
//   dmem_error           data memory fault, sampled with mem_ack in MEMORY
//   mem_ack              memory request completes this cycle
//   *_en                 one-hot stage enables
//   mem_req              memory request (FETCH, MEMORY)
//   stat                 AOK/HLT/ADR/INS
//   busy, halted, retire status strobes
//   cycle_cnt, instr_cnt performance counters (only with SEQ_CTRL_PERF_EN)
// Build option: define SEQ_CTRL_PERF_EN to add the performance counters.
module seq_stage_ctrl
   import y86_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_error,
   input  logic             dmem_error,
   input  logic             mem_ack,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             pc_en,
   output logic             mem_req,
   output logic [2:0]       stat,
   output logic             busy,
   output logic             halted,
   output logic             retire
`ifdef SEQ_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   ctrl_state_t state;
   logic [3:0]  icode_q;
   logic        timeout;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!mem_req || mem_ack),
      .count   (mem_req && !mem_ack),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         stat    <= SAOK;
         icode_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) state <= S_FETCH;
            S_FETCH: begin
               if (mem_ack) begin
                  if (imem_error) begin
                     stat  <= SADR;
                     state <= S_HALT;
                  end else if (!instr_valid) begin
                     stat  <= SINS;
                     state <= S_HALT;
                  end else if (icode == IHALT) begin
                     stat  <= SHLT;
                     state <= S_HALT;
                  end else begin
                     icode_q <= icode;
                     state   <= S_DECODE;
                  end
               end else if (timeout) begin
                  stat  <= SADR;
                  state <= S_HALT;
               end
            end
            S_DECODE: state <= S_EXECUTE;
            S_EXECUTE: begin
               if (needs_mem(icode_q))       state <= S_MEMORY;
               else if (writes_reg(icode_q)) state <= S_WRITEBACK;
               else                          state <= S_PCUPD;
            end
            S_MEMORY: begin
               if (mem_ack) begin
                  if (dmem_error) begin
                     stat  <= SADR;
                     state <= S_HALT;
                  end else if (writes_reg(icode_q)) begin
                     state <= S_WRITEBACK;
                  end else begin
                     state <= S_PCUPD;
                  end
               end else if (timeout) begin
                  stat  <= SADR;
                  state <= S_HALT;
               end
            end
            S_WRITEBACK: state <= S_PCUPD;
            S_PCUPD:     state <= S_FETCH;
            S_HALT:      state <= S_HALT;
            default:     state <= S_IDLE;
         endcase
      end
   end

   assign fetch_en  = (state == S_FETCH);
   assign decode_en = (state == S_DECODE);
   assign exec_en   = (state == S_EXECUTE);
   assign mem_en    = (state == S_MEMORY);
   assign wb_en     = (state == S_WRITEBACK);
   assign pc_en     = (state == S_PCUPD);
   assign mem_req   = fetch_en || mem_en;
   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);

   // A halt instruction retires in the FETCH cycle that accepts it,
   // since it never reaches PCUPD
   assign retire = pc_en ||
                   (fetch_en && mem_ack && !imem_error && instr_valid &&
                    icode == IHALT);

`ifdef SEQ_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (busy)   cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
module tb_seq_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] icode;
   logic       instr_valid, imem_error, dmem_error, mem_ack;
   logic       fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
   logic       mem_req, busy, halted, retire;
   logic [2:0] stat;
`ifdef SEQ_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   int errs   = 0;
   int checks = 0;

   // {enables[5:0], mem_req, retire}
   logic [7:0] obs;
   assign obs = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, mem_req, retire};

   always #5 clk = ~clk;

   seq_stage_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .icode       (icode),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .dmem_error  (dmem_error),
      .mem_ack     (mem_ack),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .exec_en     (exec_en),
      .mem_en      (mem_en),
      .wb_en       (wb_en),
      .pc_en       (pc_en),
      .mem_req     (mem_req),
      .stat        (stat),
      .busy        (busy),
      .halted      (halted),
      .retire      (retire)
`ifdef SEQ_CTRL_PERF_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instr_cnt   (instr_cnt)
`endif
   );

   // Drive one cycle's inputs on the falling edge; outputs are then
   // observed 1 time unit later, well away from the rising edge.
   task automatic drive(input logic s, input logic [3:0] ic, input logic iv,
                        input logic ie, input logic de, input logic ack);
      @(negedge clk);
      start = s; icode = ic; instr_valid = iv;
      imem_error = ie; dmem_error = de; mem_ack = ack;
      #1;
   endtask

   // Reset, then one IDLE cycle with start high; next drive() is in FETCH
   task automatic reset_and_start();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; icode = 4'd0; instr_valid = 1'b0;
      imem_error = 1'b0; dmem_error = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; icode = 4'd0; instr_valid = 1'b0;
      imem_error = 1'b0; dmem_error = 1'b0; mem_ack = 1'b0;
      #12;
      checks++; if (obs !== 8'b000000_0_0) begin errs++; $display("FAIL reset_outs: got %b want %b", obs, 8'b0); end
      checks++; if (stat !== 3'd1) begin errs++; $display("FAIL reset_stat: got %0d want 1", stat); end
      checks++; if ({busy, halted} !== 2'b00) begin errs++; $display("FAIL reset_busy_halted: got %b want 00", {busy, halted}); end
`ifdef SEQ_CTRL_PERF_EN
      checks++; if ({cycle_cnt, instr_cnt} !== 64'd0) begin errs++; $display("FAIL reset_perf: got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_no_start: busy got %b want 0", busy); end
   endtask

   task automatic test_nop();
      reset_and_start();
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++; if (obs !== 8'b100000_1_0 || busy !== 1'b1) begin errs++; $display("FAIL nop_fetch: got %b busy %b want 10000010 busy 1", obs, busy); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b010000_0_0) begin errs++; $display("FAIL nop_decode: got %b want 01000000", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b001000_0_0) begin errs++; $display("FAIL nop_exec: got %b want 00100000", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000001_0_1) begin errs++; $display("FAIL nop_pcupd: got %b want 00000101", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b100000_1_0 || stat !== 3'd1) begin errs++; $display("FAIL nop_refetch: got %b stat %0d want 10000010 stat 1", obs, stat); end
   endtask

   task automatic test_mem_waits();
      reset_and_start();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b100000_1_0) begin errs++; $display("FAIL mrm_fetch_wait: got %b want 10000010", obs); end
      drive(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b010000_0_0) begin errs++; $display("FAIL mrm_decode: got %b want 01000000", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (obs !== 8'b000100_1_0) begin errs++; $display("FAIL mrm_memory: got %b want 00010010", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000010_0_0) begin errs++; $display("FAIL mrm_wb: got %b want 00001000", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000001_0_1 || stat !== 3'd1) begin errs++; $display("FAIL mrm_pcupd_c8: got %b stat %0d want 00000101 stat 1", obs, stat); end
   endtask

   task automatic test_halt();
      reset_and_start();
      drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++; if (obs !== 8'b100000_1_1) begin errs++; $display("FAIL halt_retire: got %b want 10000011", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b0 || stat !== 3'd2 || halted !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL halt_state: got %b stat %0d halted %b busy %b want 0 2 1 0", obs, stat, halted, busy); end
      drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b0 || stat !== 3'd2 || halted !== 1'b1) begin errs++; $display("FAIL halt_ignores_start: got %b stat %0d halted %b want 0 2 1", obs, stat, halted); end
   endtask

   task automatic test_timeout();
      // data side: 4 cycles in MEMORY with no ack
      reset_and_start();
      drive(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++; if (obs !== 8'b000100_1_0) begin errs++; $display("FAIL to_mem_wait%0d: got %b want 00010010", i, obs); end
      end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b0 || stat !== 3'd3 || halted !== 1'b1) begin errs++; $display("FAIL to_mem_adr: got %b stat %0d halted %b want 0 3 1", obs, stat, halted); end
      // ack on the 4th waiting cycle beats the timeout
      reset_and_start();
      drive(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000001_0_1 || stat !== 3'd1) begin errs++; $display("FAIL to_late_ack: got %b stat %0d want 00000101 stat 1", obs, stat); end
      // fetch side timeout
      reset_and_start();
      for (int i = 0; i < 4; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (stat !== 3'd3 || halted !== 1'b1) begin errs++; $display("FAIL to_fetch_adr: stat %0d halted %b want 3 1", stat, halted); end
   endtask

   task automatic test_errors();
      reset_and_start();
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++; if (retire !== 1'b0) begin errs++; $display("FAIL err_no_retire: got %b want 0", retire); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (stat !== 3'd3 || halted !== 1'b1) begin errs++; $display("FAIL err_adr_prio: stat %0d halted %b want 3 1", stat, halted); end
      reset_and_start();
      drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (stat !== 3'd4 || halted !== 1'b1) begin errs++; $display("FAIL err_ins: stat %0d halted %b want 4 1", stat, halted); end
      // dmem error: popq goes to HALT from MEMORY, skipping WB/PCUPD
      reset_and_start();
      drive(1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b0 || stat !== 3'd3) begin errs++; $display("FAIL err_dmem: got %b stat %0d want 0 3", obs, stat); end
   endtask

   task automatic test_opq_path();
      // opq: EXECUTE goes straight to WRITEBACK
      reset_and_start();
      drive(1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (obs !== 8'b000010_0_0) begin errs++; $display("FAIL opq_wb: got %b want 00001000", obs); end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000001_0_1) begin errs++; $display("FAIL opq_pcupd: got %b want 00000101", obs); end
   endtask

   task automatic test_reset_mid();
      reset_and_start();
      drive(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000100_1_0) begin errs++; $display("FAIL rm_in_memory: got %b want 00010010", obs); end
      rst_n = 1'b0;
      #1;
      checks++; if (obs !== 8'b0 || stat !== 3'd1 || busy !== 1'b0 || halted !== 1'b0) begin errs++; $display("FAIL rm_async: got %b stat %0d busy %b halted %b want 0 1 0 0", obs, stat, busy, halted); end
      reset_and_start();
      drive(1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 8'b000001_0_1 || stat !== 3'd1) begin errs++; $display("FAIL rm_restart: got %b stat %0d want 00000101 stat 1", obs, stat); end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_mem_waits();
      test_halt();
      test_timeout();
      test_errors();
      test_opq_path();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
